// File: rtl/dft_mag_collect.sv
// dft_mag_collect: buffers one frame of DFT magnitudes, tracks the peak bin, and serves synchronous readback
module dft_mag_collect #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int FRAME_N = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] mag,
  input  logic              mag_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_idx,
  output logic              overrun,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, DONE = 2'd2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_N - 1);
  logic [1:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic              wr, last;
  // start wins over a coincident sample, so that sample is neither stored nor counted as overrun
  assign wr   = mag_valid && !start && state == COLLECT;
  assign last = wr && cnt == LAST;
  assign busy = state == COLLECT;
  always_ff @(posedge clk)
    if (wr) mem[cnt] <= mag;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
      peak_val   <= '0;
      peak_idx   <= '0;
      overrun    <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      frame_done <= last;
      rd_valid   <= rd_en;
      if (rd_en) rd_data <= mem[rd_addr];
      if (start) begin
        state    <= COLLECT;
        cnt      <= '0;
        peak_val <= '0;
        peak_idx <= '0;
        overrun  <= 1'b0;
      end else if (wr) begin
        cnt   <= last ? '0 : cnt + 1'b1;
        state <= last ? DONE : COLLECT;
        if (mag > peak_val) begin
          peak_val <= mag;
          peak_idx <= cnt;
        end
      end else if (mag_valid) overrun <= 1'b1;
    end
endmodule

// File: tb/tb_dft_mag_collect.sv
// tb_dft_mag_collect: table vectors, directed corner sequences and random traffic against a queue-based model
module tb_dft_mag_collect;
  localparam int DW = 16, AW = 8, FN = 8;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mag_valid = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] mag = '0;
  logic [AW-1:0] rd_addr = '0;
  logic busy, frame_done, overrun, rd_valid;
  logic [DW-1:0] peak_val, rd_data;
  logic [AW-1:0] peak_idx;
  dft_mag_collect #(.DATA_W(DW), .ADDR_W(AW), .FRAME_N(FN)) dut (
    .clk(clk), .rst(rst), .start(start), .mag(mag), .mag_valid(mag_valid),
    .busy(busy), .frame_done(frame_done), .peak_val(peak_val), .peak_idx(peak_idx),
    .overrun(overrun), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, fd_cnt = 0;
  bit m_col, m_ov, m_fd, m_rv, m_rd_known;
  int q[$];
  int mem_m[FN];
  bit known[FN];
  int m_rd;
  typedef struct {
    bit s; bit mv; int m; bit busy; bit fd; int pv; int pi;
  } vec_t;
  vec_t tbl[10];
  int exp_s1[8] = '{3, 9, 2, 9, 1, 0, 7, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_peak(output int v, output int i);
    v = 0; i = 0;
    foreach (q[k]) if (q[k] > v) begin v = q[k]; i = k; end
  endtask

  task automatic check_all();
    int pv, pi;
    model_peak(pv, pi);
    chk("busy", {31'd0, busy}, {31'd0, m_col});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    chk("peak_val", 32'(peak_val), pv);
    chk("peak_idx", 32'(peak_idx), pi);
    chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_rv});
    if (m_rd_known) chk("rd_data", 32'(rd_data), m_rd);
  endtask

  task automatic step(input bit s, input bit mv, input int m, input bit re, input int ra);
    start = s; mag_valid = mv; mag = DW'(m); rd_en = re; rd_addr = AW'(ra);
    if (re) begin
      m_rd_known = (ra < FN) && known[ra];
      if (m_rd_known) m_rd = mem_m[ra];
    end
    m_rv = re;
    m_fd = 0;
    if (s) begin
      q.delete(); m_ov = 0; m_col = 1;
    end else if (mv) begin
      if (m_col) begin
        mem_m[q.size()] = m; known[q.size()] = 1; q.push_back(m);
        if (q.size() == FN) begin m_fd = 1; m_col = 0; end
      end else m_ov = 1;
    end
    @(posedge clk); #1;
    start = 0; mag_valid = 0; rd_en = 0;
    if (frame_done) fd_cnt++;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; #1;
    m_col = 0; m_ov = 0; m_fd = 0; m_rv = 0; m_rd = 0; m_rd_known = 1; q.delete();
    check_all();
    @(posedge clk); #1;
    rst = 0;
    check_all();
  endtask

  initial begin
    tbl[0] = '{s: 1, mv: 0, m: 0, busy: 1, fd: 0, pv: 0, pi: 0};
    for (int k = 0; k < 8; k++)
      tbl[k+1] = '{s: 0, mv: 1, m: k, busy: (k != 7), fd: (k == 7), pv: k, pi: k};
    tbl[9] = '{s: 0, mv: 0, m: 0, busy: 0, fd: 0, pv: 7, pi: 7};
    do_reset();
    // frame of spaced bins with a tie on the peak value
    step(1, 0, 0, 0, 0);
    fd_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, 1, exp_s1[k], 0, 0);
      if (k == 7) chk("s1_fd_after_8th", {31'd0, frame_done}, 32'd1);
      if (k != 7) for (int j = 0; j < 4; j++) step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    chk("s1_fd_count", fd_cnt, 1);
    chk("s1_peak_val", 32'(peak_val), 9);
    chk("s1_peak_idx", 32'(peak_idx), 1);
    chk("s1_busy", {31'd0, busy}, 0);
    for (int a = 0; a < 8; a++) begin
      step(0, 0, 0, 1, a);
      chk("rb_data", 32'(rd_data), exp_s1[a]);
      chk("rb_valid", {31'd0, rd_valid}, 1);
    end
    step(0, 0, 0, 0, 0);
    chk("rb_valid_low", {31'd0, rd_valid}, 0);
    // sample while DONE is dropped and flagged
    step(0, 1, 100, 0, 0);
    chk("ov_set", {31'd0, overrun}, 1);
    chk("ov_peak", 32'(peak_val), 9);
    step(0, 0, 0, 1, 0);
    chk("ov_buf0", 32'(rd_data), 3);
    step(1, 0, 0, 0, 0);
    chk("ov_clear", {31'd0, overrun}, 0);
    // restart mid-frame with a coincident sample that must be discarded
    step(0, 1, 5, 0, 0); step(0, 1, 6, 0, 0); step(0, 1, 7, 0, 0);
    step(1, 1, 50, 0, 0);
    chk("rs_ov", {31'd0, overrun}, 0);
    chk("rs_peak_clr", 32'(peak_val), 0);
    fd_cnt = 0;
    for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 0);
    chk("rs_fd", fd_cnt, 1);
    chk("rs_peak_val", 32'(peak_val), 1);
    chk("rs_peak_idx", 32'(peak_idx), 0);
    // back-to-back samples from the vector table
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].mv, tbl[i].m, 0, 0);
      chk("tv_busy", {31'd0, busy}, {31'd0, tbl[i].busy});
      chk("tv_fd", {31'd0, frame_done}, {31'd0, tbl[i].fd});
      chk("tv_pv", 32'(peak_val), tbl[i].pv);
      chk("tv_pi", 32'(peak_idx), tbl[i].pi);
    end
    // reset in the middle of a frame, then a clean frame
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 20 + k, 0, 0);
    do_reset();
    chk("mr_busy", {31'd0, busy}, 0);
    chk("mr_peak", 32'(peak_val), 0);
    step(1, 0, 0, 0, 0);
    fd_cnt = 0;
    for (int k = 0; k < 8; k++) step(0, 1, 10 * k, 0, 0);
    chk("mr_fd", fd_cnt, 1);
    chk("mr_peak_idx", 32'(peak_idx), 7);
    // random traffic against the model
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535)),
                $urandom_range(0, 1) == 1, $urandom_range(0, FN - 1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
